smg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display scanner: time-slices `DIGITS` digit positions at a programmable slot period and drives the digit-select and segment lines directly. Each slot includes a configurable anti-ghosting blanking interval, per-digit decimal points, optional leading-zero blanking and a frame-done strobe. The block sits between the CPU debug/status path, which supplies `Number_Sig`, and the board display pins. It supersedes the fixed 4-digit nibble scanner and keeps its `Number_Data` output for compatibility.

---
 rtl/smg_pkg.sv | 26 ++
 rtl/smg_hex_decoder.sv | 24 ++
 rtl/smg_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_smg_scan_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// smg_pkg: shared types and constants for the seven-segment scanner.
//   seg_t     : 8-bit segment word, bit 7 = dp, bits [6:0] = segments g..a
//   SEG_DP    : bit index of the decimal point inside seg_t
//   SEG_PAT   : active-high hex glyphs 0..F (bits g..a)
//   phase_t   : what the current slot is doing on the display pins
package smg_pkg;

    typedef logic [7:0] seg_t;

    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        PH_DARK     = 2'd0,
        PH_BLANK    = 2'd1,
        PH_SHOW     = 2'd2,
        PH_SUPPRESS = 2'd3
    } phase_t;

endpackage

// File: rtl/smg_hex_decoder.sv
// smg_hex_decoder: combinational nibble + decimal point to active-high
// segment word. Output polarity is handled by the parent.
//   nibble : hex value 0..F
//   dp     : decimal point request
//   seg    : active-high segment word (bit 7 dp, bits [6:0] g..a)
module smg_hex_decoder
    import smg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    seg_t seg_w;

    always_comb begin
        seg_w         = '0;
        seg_w[6:0]    = SEG_PAT[nibble];
        seg_w[SEG_DP] = dp;
    end

    assign seg = seg_w;

endmodule

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl: multiplexed seven-segment display scanner.
// Time-slices DIGITS digit positions, most significant first, each slot being
// SCAN_TICKS cycles whose first BLANK_TICKS cycles are dark (anti-ghosting).
// All display outputs are registered and lag the slot state by one cycle.
//
// Optional build macro: SMG_LZB_EN compiles in leading-zero blanking
// (digit k > 0 is dark when it and every higher digit is 0 without dp).
//
// Ports:
//   CLK          clock, rising edge
//   RSTn         asynchronous active-low reset
//   Enable_Sig   1 = scan, 0 = display dark and scan held at its start
//   Number_Sig   4*DIGITS hex value, digit k = bits [4k+3:4k]
//   Dp_Sig       per-digit decimal point
//   Digit_Sel    one-hot digit enable (polarity per DIG_ACTIVE_LOW)
//   Seg_Data     dp + segments g..a (polarity per SEG_ACTIVE_LOW)
//   Number_Data  nibble of the digit in the current slot
//   Frame_Done   one-cycle pulse at the end of the digit-0 slot
module smg_scan_ctrl
    import smg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_TICKS     = 100000,
    parameter int BLANK_TICKS    = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  Enable_Sig,
    input  logic [4*DIGITS-1:0]   Number_Sig,
    input  logic [DIGITS-1:0]     Dp_Sig,
    output logic [DIGITS-1:0]     Digit_Sel,
    output logic [7:0]            Seg_Data,
    output logic [3:0]            Number_Data,
    output logic                  Frame_Done
);

    localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     C1_LAST  = CW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0]     C1_BLANK = CW'(BLANK_TICKS);
    localparam logic [IW-1:0]     IDX_TOP  = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [CW-1:0]     c1;
    logic [IW-1:0]     idx;
    logic [3:0]        nib_cur;
    logic              dp_cur;
    logic [DIGITS-1:0] sel_hi;
    logic              sup_cur;
    logic              slot_end;
    logic [7:0]        seg_hi;
    logic [7:0]        seg_drv;
    logic [DIGITS-1:0] dig_drv;
    phase_t            phase;

    // Digit selection by compare rather than variable indexing so that
    // DIGITS values that are not powers of two never index past the vectors.
    always_comb begin
        nib_cur = '0;
        dp_cur  = 1'b0;
        sel_hi  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib_cur   = Number_Sig[4*k +: 4];
                dp_cur    = Dp_Sig[k];
                sel_hi[k] = 1'b1;
            end
        end
    end

`ifdef SMG_LZB_EN
    logic [DIGITS-1:0] lz_mask;
    logic              lz_run;

    // Walk from the most significant digit down; a digit stays suppressed
    // only while every digit above it (and itself) is a dp-less zero.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_run = lz_run & (Number_Sig[4*k +: 4] == 4'h0) & ~Dp_Sig[k];
            if (k > 0) begin
                lz_mask[k] = lz_run;
            end
        end
    end

    assign sup_cur = |(lz_mask & sel_hi);
`else
    assign sup_cur = 1'b0;
`endif

    assign slot_end = (c1 == C1_LAST);

    always_comb begin
        phase = PH_SHOW;
        if (!Enable_Sig) begin
            phase = PH_DARK;
        end else if (c1 < C1_BLANK) begin
            phase = PH_BLANK;
        end else if (sup_cur) begin
            phase = PH_SUPPRESS;
        end
    end

    smg_hex_decoder u_dec (
        .nibble (nib_cur),
        .dp     (dp_cur),
        .seg    (seg_hi)
    );

    assign seg_drv = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    assign dig_drv = (DIG_ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            c1          <= '0;
            idx         <= IDX_TOP;
            Digit_Sel   <= DIG_OFF;
            Seg_Data    <= SEG_OFF;
            Number_Data <= '0;
            Frame_Done  <= 1'b0;
        end else begin
            Number_Data <= nib_cur;
            Frame_Done  <= Enable_Sig && slot_end && (idx == '0);

            if (phase == PH_SHOW) begin
                Digit_Sel <= dig_drv;
                Seg_Data  <= seg_drv;
            end else begin
                Digit_Sel <= DIG_OFF;
                Seg_Data  <= SEG_OFF;
            end

            // Disable parks the scan so re-enable starts a full top-digit slot.
            if (!Enable_Sig) begin
                c1  <= '0;
                idx <= IDX_TOP;
            end else if (slot_end) begin
                c1  <= '0;
                idx <= (idx == '0) ? IDX_TOP : idx - 1'b1;
            end else begin
                c1  <= c1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
module tb_smg_scan_ctrl;

    logic        CLK;
    logic        RSTn;
    logic        Enable_Sig;
    logic [15:0] Number_Sig;
    logic [3:0]  Dp_Sig;
    logic [3:0]  Digit_Sel;
    logic [7:0]  Seg_Data;
    logic [3:0]  Number_Data;
    logic        Frame_Done;

    int n_vec = 0;
    int n_bad = 0;

    smg_scan_ctrl #(
        .DIGITS         (4),
        .SCAN_TICKS     (8),
        .BLANK_TICKS    (2),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Enable_Sig  (Enable_Sig),
        .Number_Sig  (Number_Sig),
        .Dp_Sig      (Dp_Sig),
        .Digit_Sel   (Digit_Sel),
        .Seg_Data    (Seg_Data),
        .Number_Data (Number_Data),
        .Frame_Done  (Frame_Done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [15:0] num;
        logic [3:0]  dp;
        logic [3:0]  sel;
        logic [7:0]  seg;
        logic [3:0]  nd;
        logic        last;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_dark(input string name);
        chk({name, ".sel"}, {28'd0, Digit_Sel}, 32'hF);
        chk({name, ".seg"}, {24'd0, Seg_Data}, 32'hFF);
    endtask

    task automatic chk_show(input string name, input logic [3:0] sel, input logic [7:0] seg);
        chk({name, ".sel"}, {28'd0, Digit_Sel}, {28'd0, sel});
        chk({name, ".seg"}, {24'd0, Seg_Data}, {24'd0, seg});
    endtask

    initial begin
        // 1234, two frames
        for (int f = 0; f < 2; f++) begin
            tbl[4*f+0] = '{16'h1234, 4'b0000, 4'b0111, 8'hF9, 4'h1, 1'b0};
            tbl[4*f+1] = '{16'h1234, 4'b0000, 4'b1011, 8'hA4, 4'h2, 1'b0};
            tbl[4*f+2] = '{16'h1234, 4'b0000, 4'b1101, 8'hB0, 4'h3, 1'b0};
            tbl[4*f+3] = '{16'h1234, 4'b0000, 4'b1110, 8'h99, 4'h4, 1'b1};
        end
`ifdef SMG_LZB_EN
        tbl[8]  = '{16'h0070, 4'b0000, 4'b1111, 8'hFF, 4'h0, 1'b0};
        tbl[9]  = '{16'h0070, 4'b0000, 4'b1111, 8'hFF, 4'h0, 1'b0};
        tbl[12] = '{16'h0070, 4'b0100, 4'b1111, 8'hFF, 4'h0, 1'b0};
`else
        tbl[8]  = '{16'h0070, 4'b0000, 4'b0111, 8'hC0, 4'h0, 1'b0};
        tbl[9]  = '{16'h0070, 4'b0000, 4'b1011, 8'hC0, 4'h0, 1'b0};
        tbl[12] = '{16'h0070, 4'b0100, 4'b0111, 8'hC0, 4'h0, 1'b0};
`endif
        tbl[10] = '{16'h0070, 4'b0000, 4'b1101, 8'hF8, 4'h7, 1'b0};
        tbl[11] = '{16'h0070, 4'b0000, 4'b1110, 8'hC0, 4'h0, 1'b1};
        tbl[13] = '{16'h0070, 4'b0100, 4'b1011, 8'h40, 4'h0, 1'b0};
        tbl[14] = '{16'h0070, 4'b0100, 4'b1101, 8'hF8, 4'h7, 1'b0};
        tbl[15] = '{16'h0070, 4'b0100, 4'b1110, 8'hC0, 4'h0, 1'b1};

        // Reset with random inputs
        RSTn       = 1'b0;
        Enable_Sig = 1'($urandom);
        Number_Sig = 16'($urandom);
        Dp_Sig     = 4'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            Enable_Sig = 1'($urandom);
            Number_Sig = 16'($urandom);
            Dp_Sig     = 4'($urandom);
        end
        chk_dark("reset");
        chk("reset.nd", {28'd0, Number_Data}, 32'h0);
        chk("reset.fd", {31'd0, Frame_Done}, 32'h0);

        // Release into a continuous scan driven from the table
        Enable_Sig = 1'b1;
        Number_Sig = 16'h1234;
        Dp_Sig     = 4'b0000;
        RSTn       = 1'b1;
        for (int v = 0; v < 16; v++) begin
            Number_Sig = tbl[v].num;
            Dp_Sig     = tbl[v].dp;
            for (int j = 0; j < 8; j++) begin
                step();
                if (j < 2) chk_dark($sformatf("vec%0d.blank%0d", v, j));
                else       chk_show($sformatf("vec%0d.show%0d", v, j), tbl[v].sel, tbl[v].seg);
                chk($sformatf("vec%0d.nd%0d", v, j), {28'd0, Number_Data}, {28'd0, tbl[v].nd});
                chk($sformatf("vec%0d.fd%0d", v, j), {31'd0, Frame_Done},
                    {31'd0, (tbl[v].last && j == 7)});
            end
        end

        // Live update mid-slot: digit 3 slot, then into digit 2
        Number_Sig = 16'h1234;
        Dp_Sig     = 4'b0000;
        for (int j = 0; j < 8; j++) step();
        for (int j = 0; j < 5; j++) step();
        chk_show("live.before", 4'b1011, 8'hA4);
        Number_Sig = 16'h18A4;
        Dp_Sig     = 4'b0100;
        step();
        chk_show("live.after", 4'b1011, 8'h00);
        chk("live.nd", {28'd0, Number_Data}, 32'h8);

        // Enable drop mid-slot, then restore
        Enable_Sig = 1'b0;
        step();
        chk_dark("dis.first");
        chk("dis.fd", {31'd0, Frame_Done}, 32'h0);
        step();
        step();
        chk_dark("dis.hold");
        Enable_Sig = 1'b1;
        Number_Sig = 16'h1234;
        Dp_Sig     = 4'b0000;
        for (int j = 1; j <= 9; j++) begin
            step();
            if (j <= 2 || j == 9) chk_dark($sformatf("ena.c%0d", j));
            else                  chk_show($sformatf("ena.c%0d", j), 4'b0111, 8'hF9);
        end
        chk("ena.nd", {28'd0, Number_Data}, 32'h2);

        // Reset asserted mid-show
        step();
        step();
        step();
        chk_show("rst.pre", 4'b1011, 8'hA4);
        RSTn = 1'b0;
        #1;
        chk_dark("rst.async");
        chk("rst.nd", {28'd0, Number_Data}, 32'h0);
        chk("rst.fd", {31'd0, Frame_Done}, 32'h0);
        RSTn = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            step();
            if (j <= 2) chk_dark($sformatf("rel.c%0d", j));
            else        chk_show("rel.show", 4'b0111, 8'hF9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
